// File: rtl/splitter_pkg.sv
// ----------------------------------------------------------------------------
// splitter_pkg
//   Shared definitions for the list splitter: list geometry, split_sel mode
//   codes, FSM state type and the group-size / group-count / two-beat tables
//   used to decode a mode.  The lane-map helpers are constant functions, so
//   the routing network elaborates to pure wiring.
// ----------------------------------------------------------------------------
package splitter_pkg;

   localparam int WIDTH    = 32;         // bits per coefficient
   localparam int SIZE     = 257;        // elements per list
   localparam int N_ADDERS = 51;         // adder lanes (max groups, G=5)
   localparam int N_LANES  = SIZE - 1;   // BFA / multiplier lanes

   // split_sel codes; 3 and 7 are unused and fall back to MODE_G257
   localparam logic [2:0] MODE_G257    = 3'd0;
   localparam logic [2:0] MODE_G17     = 3'd1;
   localparam logic [2:0] MODE_G5      = 3'd2;
   localparam logic [2:0] MODE_G257_2B = 3'd4;
   localparam logic [2:0] MODE_G17_2B  = 3'd5;
   localparam logic [2:0] MODE_G5_2B   = 3'd6;

   typedef enum logic [1:0] {
      GSEL_257 = 2'd0,
      GSEL_17  = 2'd1,
      GSEL_5   = 2'd2
   } gsel_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BEAT0 = 2'd1,
      ST_BEAT1 = 2'd2
   } state_e;

   typedef struct packed {
      gsel_e gsel;
      logic  two_beat;
   } mode_t;

   // Decode split_sel into group size selector and beat count.
   function automatic mode_t decode_sel(input logic [2:0] sel);
      mode_t m;
      m.gsel     = GSEL_257;
      m.two_beat = 1'b0;
      case (sel)
         MODE_G17,  MODE_G17_2B: m.gsel = GSEL_17;
         MODE_G5,   MODE_G5_2B:  m.gsel = GSEL_5;
         default:                m.gsel = GSEL_257;
      endcase
      m.two_beat = (sel == MODE_G257_2B) || (sel == MODE_G17_2B) ||
                   (sel == MODE_G5_2B);
      return m;
   endfunction

   // Group size G for a selector.
   function automatic int group_size(input gsel_e g);
      case (g)
         GSEL_17: return 17;
         GSEL_5:  return 5;
         default: return 257;
      endcase
   endfunction

   // Number of complete groups in one list (1 / 15 / 51).
   function automatic int num_groups(input gsel_e g);
      return SIZE / group_size(g);
   endfunction

   // List element feeding BFA/mult lane j.  Lanes belonging to a group that
   // is not complete (past num_groups) return SIZE, which indexes the
   // all-zero pad element appended by the router.
   function automatic int lane_elem(input gsel_e g, input int j);
      int gs;
      int grp;
      gs  = group_size(g);
      grp = j / (gs - 1);
      if (grp >= num_groups(g)) return SIZE;
      return grp * gs + 1 + (j % (gs - 1));
   endfunction

   // List element feeding adder lane grp on the given beat (0 -> element 0
   // of the group, 1 -> element 1); SIZE (zero pad) past the last group.
   function automatic int adder_elem(input gsel_e g, input int grp, input int b);
      if (grp >= num_groups(g)) return SIZE;
      return grp * group_size(g) + b;
   endfunction

endpackage

// File: rtl/splitter_route.sv
// ----------------------------------------------------------------------------
// splitter_route
//   Combinational lane map.  Scatters a SIZE-element list into N_LANES
//   BFA/mult operand lanes and N_ADDERS adder lanes for the selected group
//   size.  Every lane is a 3:1 mux over constant wiring (one tap per group
//   size), plus a beat select on the adder lanes.
//
//   i_list    SIZE*WIDTH      element k at [(k+1)*WIDTH-1 -: WIDTH]
//   i_gsel    gsel_e          group size selector (257 / 17 / 5)
//   i_beat    1               adder beat: 0 -> element 0, 1 -> element 1
//   o_lanes   N_LANES*WIDTH   lane j = element 1+(j%(G-1)) of group j/(G-1)
//   o_adders  N_ADDERS*WIDTH  lane g = element i_beat of group g
// ----------------------------------------------------------------------------
module splitter_route
   import splitter_pkg::*;
(
   input  logic [SIZE*WIDTH-1:0]     i_list,
   input  gsel_e                     i_gsel,
   input  logic                      i_beat,
   output logic [N_LANES*WIDTH-1:0]  o_lanes,
   output logic [N_ADDERS*WIDTH-1:0] o_adders
);

   // Element SIZE is a constant zero so lanes outside a complete group
   // resolve to 0 through the same wiring as every other lane.
   logic [(SIZE+1)*WIDTH-1:0] w_ext;
   assign w_ext = {{WIDTH{1'b0}}, i_list};

   for (genvar j = 0; j < N_LANES; j++) begin : g_lane
      localparam int E257 = lane_elem(GSEL_257, j);
      localparam int E17  = lane_elem(GSEL_17,  j);
      localparam int E5   = lane_elem(GSEL_5,   j);

      logic [WIDTH-1:0] w_e257, w_e17, w_e5;
      assign w_e257 = w_ext[E257*WIDTH +: WIDTH];
      assign w_e17  = w_ext[E17*WIDTH  +: WIDTH];
      assign w_e5   = w_ext[E5*WIDTH   +: WIDTH];

      assign o_lanes[j*WIDTH +: WIDTH] = (i_gsel == GSEL_17) ? w_e17 :
                                         (i_gsel == GSEL_5)  ? w_e5  :
                                                               w_e257;
   end

   for (genvar g = 0; g < N_ADDERS; g++) begin : g_add
      localparam int A257_0 = adder_elem(GSEL_257, g, 0);
      localparam int A257_1 = adder_elem(GSEL_257, g, 1);
      localparam int A17_0  = adder_elem(GSEL_17,  g, 0);
      localparam int A17_1  = adder_elem(GSEL_17,  g, 1);
      localparam int A5_0   = adder_elem(GSEL_5,   g, 0);
      localparam int A5_1   = adder_elem(GSEL_5,   g, 1);

      logic [WIDTH-1:0] w_b0, w_b1;
      assign w_b0 = (i_gsel == GSEL_17) ? w_ext[A17_0*WIDTH  +: WIDTH] :
                    (i_gsel == GSEL_5)  ? w_ext[A5_0*WIDTH   +: WIDTH] :
                                          w_ext[A257_0*WIDTH +: WIDTH];
      assign w_b1 = (i_gsel == GSEL_17) ? w_ext[A17_1*WIDTH  +: WIDTH] :
                    (i_gsel == GSEL_5)  ? w_ext[A5_1*WIDTH   +: WIDTH] :
                                          w_ext[A257_1*WIDTH +: WIDTH];

      assign o_adders[g*WIDTH +: WIDTH] = i_beat ? w_b1 : w_b0;
   end

endmodule

// File: rtl/splitter.sv
// ----------------------------------------------------------------------------
// splitter
//   Inverse of the list merger.  Accepts one SIZE-element coefficient list
//   and presents it as BFA operands (one-beat modes 0-2) or multiplier
//   operands (two-beat modes 4-6), with one adder operand per group.  In
//   two-beat modes a second beat swaps the adder lanes to element 1 of each
//   group while the multiplier lanes hold.  All outputs are registered.
//
//   clk            in   1               rising-edge clock
//   rst            in   1               asynchronous active-high reset
//   in_valid       in   1               input_list / split_sel valid
//   in_ready       out  1               list can be accepted this cycle
//   input_list     in   SIZE*WIDTH      element k at [(k+1)*WIDTH-1 -: WIDTH]
//   split_sel      in   3               0/1/2 one-beat G=257/17/5, 4/5/6 two-beat
//   out_valid      out  1               operand buses valid
//   out_ready      in   1               downstream takes current beat
//   beat           out  1               adder beat index (two-beat modes)
//   bfa_in         out  N_LANES*WIDTH   BFA lanes, zero in modes 4-6
//   mult_in        out  N_LANES*WIDTH   multiplier lanes, zero in modes 0-2
//   adder_operand  out  N_ADDERS*WIDTH  adder lanes, zero past last group
// ----------------------------------------------------------------------------
module splitter
   import splitter_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [SIZE*WIDTH-1:0]     input_list,
   input  logic [2:0]                split_sel,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      beat,
   output logic [N_LANES*WIDTH-1:0]  bfa_in,
   output logic [N_LANES*WIDTH-1:0]  mult_in,
   output logic [N_ADDERS*WIDTH-1:0] adder_operand
);

   state_e                    r_state;
   mode_t                     r_mode;
   logic [SIZE*WIDTH-1:0]     r_list;

   logic                      w_final_beat;
   logic                      w_accept;
   logic                      w_to_beat1;
   mode_t                     w_in_mode;
   mode_t                     w_route_mode;
   logic [SIZE*WIDTH-1:0]     w_route_list;
   logic                      w_route_beat;
   logic [N_LANES*WIDTH-1:0]  w_lanes;
   logic [N_ADDERS*WIDTH-1:0] w_adders;

   // The beat currently on the outputs is the last one of its list.
   always_comb begin
      // NOTE: every always_comb output gets a default before the case so no
      // path leaves it unassigned, which would otherwise infer a latch.
      w_final_beat = 1'b0;
      case (r_state)
         ST_BEAT0: w_final_beat = ~r_mode.two_beat;
         ST_BEAT1: w_final_beat = 1'b1;
         default:  w_final_beat = 1'b0;
      endcase
   end

   // A new list may enter while the final beat is being consumed, giving
   // back-to-back lists in one-beat modes without a bubble.
   assign in_ready   = (r_state == ST_IDLE) | (out_ready & w_final_beat);
   assign w_accept   = in_valid & in_ready;
   assign w_to_beat1 = (r_state == ST_BEAT0) & r_mode.two_beat & out_ready;
   assign w_in_mode  = decode_sel(split_sel);

   // On accept the router works straight from the input so beat 0 lands in
   // the output register one cycle after the handshake; otherwise it reads
   // the captured list to build beat 1.
   assign w_route_mode = w_accept ? w_in_mode  : r_mode;
   assign w_route_list = w_accept ? input_list : r_list;
   assign w_route_beat = ~w_accept;

   splitter_route u_route (
      .i_list   (w_route_list),
      .i_gsel   (w_route_mode.gsel),
      .i_beat   (w_route_beat),
      .o_lanes  (w_lanes),
      .o_adders (w_adders)
   );

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_mode        <= '{gsel: GSEL_257, two_beat: 1'b0};
         // NOTE: the wide capture register is reset too; it is plain flops,
         // not a RAM, and a clean reset keeps beat 1 deterministic.
         r_list        <= '0;
         out_valid     <= 1'b0;
         beat          <= 1'b0;
         bfa_in        <= '0;
         mult_in       <= '0;
         adder_operand <= '0;
      end else begin
         case (r_state)
            ST_IDLE, ST_BEAT0, ST_BEAT1: begin
               if (w_accept) begin
                  // New list: capture it and publish beat 0.
                  r_state       <= ST_BEAT0;
                  r_mode        <= w_in_mode;
                  r_list        <= input_list;
                  out_valid     <= 1'b1;
                  beat          <= 1'b0;
                  bfa_in        <= w_in_mode.two_beat ? '0 : w_lanes;
                  mult_in       <= w_in_mode.two_beat ? w_lanes : '0;
                  adder_operand <= w_adders;
               end else if (w_to_beat1) begin
                  // Second adder beat; multiplier lanes hold.
                  r_state       <= ST_BEAT1;
                  beat          <= 1'b1;
                  adder_operand <= w_adders;
               end else if ((r_state != ST_IDLE) && out_ready) begin
                  // Final beat consumed with nothing new waiting.
                  r_state       <= ST_IDLE;
                  out_valid     <= 1'b0;
                  beat          <= 1'b0;
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               out_valid <= 1'b0;
               beat      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_splitter.sv
// ----------------------------------------------------------------------------
// tb_splitter
//   Directed self-checking bench for splitter.  Inputs change on the falling
//   edge; outputs are sampled on the falling edge after the active edge.
// ----------------------------------------------------------------------------
module tb_splitter;
   import splitter_pkg::*;

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      in_valid;
   logic                      in_ready;
   logic [SIZE*WIDTH-1:0]     input_list;
   logic [2:0]                split_sel;
   logic                      out_valid;
   logic                      out_ready;
   logic                      beat;
   logic [N_LANES*WIDTH-1:0]  bfa_in;
   logic [N_LANES*WIDTH-1:0]  mult_in;
   logic [N_ADDERS*WIDTH-1:0] adder_operand;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   splitter dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .input_list    (input_list),
      .split_sel     (split_sel),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .beat          (beat),
      .bfa_in        (bfa_in),
      .mult_in       (mult_in),
      .adder_operand (adder_operand)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Offer a list with element k = base + k.
   task automatic drive(input logic [2:0] sel, input int base);
      split_sel = sel;
      for (int k = 0; k < SIZE; k++) input_list[k*WIDTH +: WIDTH] = 32'(base + k);
      in_valid = 1'b1;
   endtask

   // Expected lane value: lane j carries element 1+(j%(G-1)) of group
   // j/(G-1); only the SIZE/G complete groups are populated.
   function automatic logic [31:0] exp_lane(input int gs, input int base, input int j);
      int grp;
      grp = j / (gs - 1);
      if (grp >= SIZE / gs) return 32'd0;
      return 32'(base + grp * gs + 1 + (j % (gs - 1)));
   endfunction

   function automatic logic [31:0] exp_adder(input int gs, input int base, input int g, input int b);
      if (g >= SIZE / gs) return 32'd0;
      return 32'(base + g * gs + b);
   endfunction

   // Full comparison of one valid output beat.
   task automatic check_out(input string tag, input int gs, input bit two, input int base, input bit b);
      check({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, " beat"}, {31'd0, beat}, {31'd0, b});
      for (int j = 0; j < N_LANES; j++) begin
         check($sformatf("%s bfa[%0d]", tag, j), bfa_in[j*WIDTH +: WIDTH],
               two ? 32'd0 : exp_lane(gs, base, j));
         check($sformatf("%s mult[%0d]", tag, j), mult_in[j*WIDTH +: WIDTH],
               two ? exp_lane(gs, base, j) : 32'd0);
      end
      for (int g = 0; g < N_ADDERS; g++)
         check($sformatf("%s add[%0d]", tag, g), adder_operand[g*WIDTH +: WIDTH],
               exp_adder(gs, base, g, int'(b)));
   endtask

   task automatic check_zero(input string tag);
      check({tag, " out_valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, " beat"}, {31'd0, beat}, 32'd0);
      for (int j = 0; j < N_LANES; j++) begin
         check($sformatf("%s bfa[%0d]", tag, j), bfa_in[j*WIDTH +: WIDTH], 32'd0);
         check($sformatf("%s mult[%0d]", tag, j), mult_in[j*WIDTH +: WIDTH], 32'd0);
      end
      for (int g = 0; g < N_ADDERS; g++)
         check($sformatf("%s add[%0d]", tag, g), adder_operand[g*WIDTH +: WIDTH], 32'd0);
   endtask

   // Rebuild the covered part of a mode-1 list the way the merger would
   // (adder lane = element 0, 16 BFA lanes = elements 1..16 of each group).
   task automatic check_roundtrip(input string tag, input int base);
      logic [31:0] rec [SIZE];
      for (int k = 0; k < SIZE; k++) rec[k] = 32'd0;
      for (int g = 0; g < 15; g++) begin
         rec[g*17] = adder_operand[g*WIDTH +: WIDTH];
         for (int i = 0; i < 16; i++) rec[g*17+1+i] = bfa_in[(g*16+i)*WIDTH +: WIDTH];
      end
      for (int k = 0; k < 255; k++)
         check($sformatf("%s elem[%0d]", tag, k), rec[k], 32'(base + k));
   endtask

   initial begin
      rst        = 1'b1;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      split_sel  = 3'd0;
      input_list = '0;
      repeat (2) @(negedge clk);
      check_zero("reset");
      check("reset in_ready", {31'd0, in_ready}, 32'd1);
      rst = 1'b0;

      // Mode 0, element k = k: lane j = j+1, adder lane 0 = 0.
      out_ready = 1'b1;
      drive(MODE_G257, 0);
      @(negedge clk); in_valid = 1'b0;
      check_out("m0", 257, 1'b0, 0, 1'b0);
      check("m0 in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      check("m0 done", {31'd0, out_valid}, 32'd0);

      // Mode 2: adder g = 5g, bfa lane j = 5*(j/4)+1+(j%4) for j < 204.
      drive(MODE_G5, 0);
      @(negedge clk); in_valid = 1'b0;
      check_out("m2", 5, 1'b0, 0, 1'b0);
      @(negedge clk);
      check("m2 done", {31'd0, out_valid}, 32'd0);

      // Unused select codes fall back to mode 0.
      drive(3'd3, 7);
      @(negedge clk); in_valid = 1'b0;
      check_out("sel3", 257, 1'b0, 7, 1'b0);
      drive(3'd7, 11);
      @(negedge clk); in_valid = 1'b0;
      check_out("sel7", 257, 1'b0, 11, 1'b0);
      @(negedge clk);

      // Mode 5, element k = k+100: two beats, in_ready low during beat 0.
      drive(MODE_G17_2B, 100);
      @(negedge clk); in_valid = 1'b0;
      check_out("m5 b0", 17, 1'b1, 100, 1'b0);
      check("m5 b0 in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      check_out("m5 b1", 17, 1'b1, 100, 1'b1);
      check("m5 b1 in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      check("m5 done", {31'd0, out_valid}, 32'd0);

      // Back-to-back mode 1 lists, one per cycle.
      drive(MODE_G17, 1000);
      @(negedge clk);
      check_out("b2b0", 17, 1'b0, 1000, 1'b0);
      check_roundtrip("rt0", 1000);
      check("b2b0 in_ready", {31'd0, in_ready}, 32'd1);
      drive(MODE_G17, 2000);
      @(negedge clk);
      check_out("b2b1", 17, 1'b0, 2000, 1'b0);
      drive(MODE_G17, 3000);
      @(negedge clk); in_valid = 1'b0;
      check_out("b2b2", 17, 1'b0, 3000, 1'b0);
      check_roundtrip("rt2", 3000);
      @(negedge clk);
      check("b2b done", {31'd0, out_valid}, 32'd0);

      // Backpressure in beat 1 of mode 6 while another list is offered.
      drive(MODE_G5_2B, 500);
      @(negedge clk); in_valid = 1'b0;
      check_out("m6 b0", 5, 1'b1, 500, 1'b0);
      @(negedge clk);
      out_ready = 1'b0;
      drive(MODE_G257, 9000);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check_out($sformatf("bp%0d", c), 5, 1'b1, 500, 1'b1);
         check($sformatf("bp%0d in_ready", c), {31'd0, in_ready}, 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("bp done", {31'd0, out_valid}, 32'd0);

      // Asynchronous reset during beat 0 of mode 4.
      out_ready = 1'b0;
      drive(MODE_G257_2B, 50);
      @(negedge clk); in_valid = 1'b0;
      check_out("m4 b0", 257, 1'b1, 50, 1'b0);
      #2 rst = 1'b1;
      #1 check_zero("mid rst");
      @(negedge clk);
      rst = 1'b0;
      check("post rst in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      check("post rst out_valid", {31'd0, out_valid}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
